ps2_scancode_rx: RTL
====================

// Module: ps2_scancode_rx
// PURPOSE
//  Parametrised PS/2 keyboard receiver. It synchronises and glitch-filters kclk/kdata, then
//  deframes 11-bit frames (start, 8 data bits LSB first, odd parity, stop).
//  It checks parity, stop bit and inter-bit timeout, and keeps an N-byte scancode history.
//  It decodes E0/F0 prefixes into one key event per key. Sits between the board PS/2 pins
//  and the game input controller (Space, Left Shift, arrow keys).
// PARAMETERS
//  SYNC_STAGES     2      flops in the kclk/kdata synchroniser chain (>=2)
//  FILTER_CYCLES   8      consecutive equal samples before the filtered kclk changes (>=1)
//  TIMEOUT_CYCLES  20000  max clk cycles between kclk falling edges inside a frame (200 us @100 MHz)
//  HISTORY_DEPTH   4      bytes kept in keycodeout (>=1)
// PORTS
//  clk          in   1                  system clock, 100 MHz
//  rst_n        in   1                  synchronous reset, active-low
//  kclk         in   1                  PS/2 clock pin, asynchronous
//  kdata        in   1                  PS/2 data pin, asynchronous
//  keycodeout   out  8*HISTORY_DEPTH    byte history; [7:0] = newest byte
//  byte_valid   out  1                  1-cycle pulse: a good byte was just shifted into keycodeout
//  frame_err    out  1                  1-cycle pulse: parity, stop or timeout error
//  key_valid    out  1                  1-cycle pulse: key event on key_code/key_ext/key_release
//  key_code     out  8                  scancode of the last key event (held until the next event)
//  key_ext      out  1                  last key event was preceded by E0
//  key_release  out  1                  last key event was preceded by F0
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): all outputs 0, keycodeout 0, FSM IDLE, counters and
//   prefix flags cleared, synchroniser/filter loaded to 1. Reset mid-frame discards the frame,
//   with no pulse.
//  Input path: SYNC_STAGES flops, then the filter. filt_kclk takes the synced value only after
//   FILTER_CYCLES consecutive equal samples. fall = filt_kclk 1->0. kdata is sampled as the
//   synced kdata in the fall cycle.
//  Latency: stop-bit pin edge -> fall after SYNC_STAGES+FILTER_CYCLES clks. byte_valid or
//   frame_err is registered 1 clk after fall.
//  FSM:
//   - IDLE: on fall with kdata=0 -> DATA, bit_cnt=0. On fall with kdata=1, stay IDLE silently.
//   - DATA: each fall shifts in one bit, LSB first; after the 8th -> PARITY.
//   - PARITY: on fall, capture p -> STOP.
//   - STOP: on fall -> IDLE. Good frame = stop bit 1 AND ^{data,p}==1: pulse byte_valid.
//     Otherwise pulse frame_err.
//  Timeout: in any state other than IDLE, tcnt increments each clk and clears on fall.
//   tcnt==TIMEOUT_CYCLES-1 -> frame_err pulse, go IDLE, partial byte dropped.
//   fall in the same cycle as expiry: fall wins (tcnt clears, no error).
//   tcnt width = $clog2(TIMEOUT_CYCLES+1).
//  History: on a good byte, keycodeout <= {keycodeout[8*HISTORY_DEPTH-9:0], byte}.
//   HISTORY_DEPTH=1 is a plain load. The oldest byte falls off.
//   A frame error leaves keycodeout unchanged.
//  Key decoder (acts only on good bytes, same cycle as byte_valid):
//   - 0xE0: set ext_pend, no key_valid.
//   - 0xF0: set rel_pend, no key_valid.
//   - Any other byte: key_valid=1, key_code=byte, key_ext=ext_pend, key_release=rel_pend,
//     then clear both pend flags.
//   - frame_err clears both pend flags, so a corrupted prefix never leaks onto the next key.
//  byte_valid, frame_err and key_valid are never asserted for two consecutive cycles.
//   byte_valid and frame_err are mutually exclusive.
// TESTING (PS/2 half-period 20 us, 50 us gap between bytes; check 1 us after each byte)
//  1 Send 1C -> byte_valid x1; keycodeout[7:0]=1C; key_valid, key_code=1C, key_ext=0, key_release=0.
//  2 Send 1C 23 2B 29 12 (HISTORY_DEPTH=4) -> keycodeout=23_2B_29_12; 1C has shifted out.
//  3 Send E0 F0 6B -> exactly one key_valid; key_code=6B, ext=1, rel=1;
//    keycodeout[23:0]=E0F06B. Then E0 75 -> key_code=75, ext=1, rel=0.
//  4 Send 1C with bad parity -> frame_err x1, no byte_valid, keycodeout unchanged.
//    Send F0 then a bad frame then 1C -> key_release=0.
//  5 Hold kclk high 250 us after the 4th data bit -> frame_err at 200 us;
//    a following good 29 is received correctly.
//  6 Inject 3-clk kclk glitches mid-bit, then pull rst_n low mid-frame for 1 clk
//    -> no extra bits, no pulses; all outputs 0; the next full frame decodes normally.

Source files
------------

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: pin synchroniser, kclk glitch filter, 11-bit frame
// deframer with parity/stop/timeout checks, byte history and E0/F0 key decoder.
`timescale 1ns/1ps
module ps2_scancode_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int HISTORY_DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       kclk,
    input  logic                       kdata,
    output logic [8*HISTORY_DEPTH-1:0] keycodeout,
    output logic                       byte_valid,
    output logic                       frame_err,
    output logic                       key_valid,
    output logic [7:0]                 key_code,
    output logic                       key_ext,
    output logic                       key_release
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int KW = 8 * HISTORY_DEPTH;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] kclk_sync_q, kclk_sync_d;
    logic [SYNC_STAGES-1:0] kdata_sync_q, kdata_sync_d;
    logic                   filt_q, filt_d;
    logic                   filt_prev_q, filt_prev_d;
    logic [FW-1:0]          fcnt_q, fcnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [KW-1:0]          keycodeout_q, keycodeout_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   key_valid_q, key_valid_d;
    logic [7:0]             key_code_q, key_code_d;
    logic                   key_ext_q, key_ext_d;
    logic                   key_release_q, key_release_d;
    logic                   ext_pend_q, ext_pend_d;
    logic                   rel_pend_q, rel_pend_d;

    logic          fall_s;
    logic          kdata_s;
    logic          timeout_s;
    logic          frame_done_s;
    logic          good_s;
    logic [KW-1:0] hist_shift_s;

    assign fall_s    = filt_prev_q & ~filt_q;
    assign kdata_s   = kdata_sync_q[SYNC_STAGES-1];
    assign timeout_s = (state_q != IDLE) && !fall_s && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    // A one-byte history is a plain load; deeper histories shift the newest byte in at the bottom.
    generate
        if (HISTORY_DEPTH == 1) begin : g_hist_load
            assign hist_shift_s = shift_q;
        end else begin : g_hist_shift
            assign hist_shift_s = {keycodeout_q[KW-9:0], shift_q};
        end
    endgenerate

    // State register and all datapath flops, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            kclk_sync_q   <= '1;
            kdata_sync_q  <= '1;
            filt_q        <= 1'b1;
            filt_prev_q   <= 1'b1;
            fcnt_q        <= '0;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            par_q         <= 1'b0;
            tcnt_q        <= '0;
            keycodeout_q  <= '0;
            byte_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            key_valid_q   <= 1'b0;
            key_code_q    <= 8'h00;
            key_ext_q     <= 1'b0;
            key_release_q <= 1'b0;
            ext_pend_q    <= 1'b0;
            rel_pend_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            kclk_sync_q   <= kclk_sync_d;
            kdata_sync_q  <= kdata_sync_d;
            filt_q        <= filt_d;
            filt_prev_q   <= filt_prev_d;
            fcnt_q        <= fcnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            tcnt_q        <= tcnt_d;
            keycodeout_q  <= keycodeout_d;
            byte_valid_q  <= byte_valid_d;
            frame_err_q   <= frame_err_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            key_ext_q     <= key_ext_d;
            key_release_q <= key_release_d;
            ext_pend_q    <= ext_pend_d;
            rel_pend_q    <= rel_pend_d;
        end
    end

    // Next-state logic of the frame FSM; a timeout from any busy state returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fall_s && !kdata_s) state_d = DATA;
                else                    state_d = IDLE;
            end
            DATA: begin
                if (timeout_s)                        state_d = IDLE;
                else if (fall_s && bit_cnt_q == 3'd7) state_d = PARITY;
                else                                  state_d = DATA;
            end
            PARITY: begin
                if (timeout_s)   state_d = IDLE;
                else if (fall_s) state_d = STOP;
                else             state_d = PARITY;
            end
            STOP: begin
                if (timeout_s || fall_s) state_d = IDLE;
                else                     state_d = STOP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Input conditioning: synchroniser shift and kclk filter that needs a stable run before switching.
    always_comb begin
        kclk_sync_d  = {kclk_sync_q[SYNC_STAGES-2:0], kclk};
        kdata_sync_d = {kdata_sync_q[SYNC_STAGES-2:0], kdata};
        filt_prev_d  = filt_q;
        filt_d       = filt_q;
        fcnt_d       = '0;
        if (kclk_sync_q[SYNC_STAGES-1] != filt_q) begin
            if (fcnt_q == FW'(FILTER_CYCLES - 1)) begin
                filt_d = kclk_sync_q[SYNC_STAGES-1];
                fcnt_d = '0;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end else begin
            fcnt_d = '0;
        end
    end

    // Output/datapath logic: bit capture, frame verdict, history and prefix-aware key decoding.
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_d         = par_q;
        keycodeout_d  = keycodeout_q;
        key_code_d    = key_code_q;
        key_ext_d     = key_ext_q;
        key_release_d = key_release_q;
        ext_pend_d    = ext_pend_q;
        rel_pend_d    = rel_pend_q;
        key_valid_d   = 1'b0;

        if (state_q == IDLE || fall_s || timeout_s) tcnt_d = '0;
        else                                        tcnt_d = tcnt_q + TW'(1);

        if (state_q == IDLE && fall_s && !kdata_s) begin
            bit_cnt_d = 3'd0;
        end else if (state_q == DATA && fall_s) begin
            shift_d   = {kdata_s, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end else if (state_q == PARITY && fall_s) begin
            par_d = kdata_s;
        end else begin
            bit_cnt_d = bit_cnt_q;
        end

        // Odd parity over data plus parity bit, and a high stop bit, make a good frame.
        frame_done_s = (state_q == STOP) && fall_s;
        good_s       = frame_done_s && kdata_s && (^{shift_q, par_q});
        byte_valid_d = good_s;
        frame_err_d  = (frame_done_s && !good_s) || timeout_s;

        if (good_s) begin
            keycodeout_d = hist_shift_s;
            if (shift_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                rel_pend_d = 1'b1;
            end else begin
                key_valid_d   = 1'b1;
                key_code_d    = shift_q;
                key_ext_d     = ext_pend_q;
                key_release_d = rel_pend_q;
                ext_pend_d    = 1'b0;
                rel_pend_d    = 1'b0;
            end
        end else if (frame_err_d) begin
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
        end else begin
            keycodeout_d = keycodeout_q;
        end
    end

    assign keycodeout  = keycodeout_q;
    assign byte_valid  = byte_valid_q;
    assign frame_err   = frame_err_q;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign key_ext     = key_ext_q;
    assign key_release = key_release_q;
endmodule
